// File: rtl/bram_pkg.sv
// Shared defaults and helpers for the BRAM port arbiter.
package bram_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_NUM_COL    = 4;
  localparam int DEF_COL_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 9;

  // Width of an index that can name any of n requesters (at least 1 bit).
  function automatic int rsp_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the arbiter: flat per-requester request fields
// plus the per-requester response strobe and shared read data.
interface bram_port_arbiter_if
  import bram_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*NUM_COL-1:0]    req_we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]         rsp_rdata_o;

  // Requesters drive the request fields and observe grant/response.
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  // The arbiter consumes requests and returns grant/response.
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Combinational round-robin priority search: first set request at or
// after ptr_i (wrapping), returned one-hot.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  int          pos;
  logic [PW-1:0] idx;
  logic        found;

  // Walk N slots starting at the pointer; the first requester seen wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one byte-write RAM port among NUM_REQ
// requesters. Grants are combinational; responses return one cycle
// after each transfer with the RAM's registered read data.
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  bram_port_arbiter_if.slave              bus,
  output logic                            ram_en_o,
  output logic [NUM_COL-1:0]              ram_we_o,
  output logic [ADDR_WIDTH-1:0]           ram_addr_o,
  output logic [NUM_COL*COL_WIDTH-1:0]    ram_wdata_o,
  input  logic [NUM_COL*COL_WIDTH-1:0]    ram_rdata_i
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int SW         = rsp_sel_w(NUM_REQ);

  logic [NUM_REQ-1:0]    gnt, ready;
  logic                  xfer;
  logic [SW-1:0]         gidx;
  logic [NUM_COL-1:0]    we_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] rsp_sel_q, rsp_sel_d;
  logic          rsp_pend_q, rsp_pend_d;

  rr_arbiter #(.N(NUM_REQ), .PW(SW)) u_rr_arbiter (
    .req_i (bus.req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  // Gate grants with reset, pick the granted payload, advance the pointer.
  always_comb begin
    ready     = rst_ni ? gnt : '0;
    xfer      = |ready;
    gidx      = '0;
    we_mux    = '0;
    addr_mux  = '0;
    wdata_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        gidx      = SW'(i);
        we_mux    = bus.req_we_i[i*NUM_COL +: NUM_COL];
        addr_mux  = bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_mux = bus.req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (gidx == SW'(NUM_REQ - 1)) ? '0 : gidx + SW'(1);
    // Every transfer, read or write, owes exactly one response next cycle.
    rsp_pend_d = xfer;
    rsp_sel_d  = xfer ? gidx : rsp_sel_q;
  end

  // Decode the pending response onto its requester's strobe.
  always_comb begin
    bus.rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (rsp_pend_q && (rsp_sel_q == SW'(i))) bus.rsp_valid_o[i] = 1'b1;
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_rdata_o = ram_rdata_i;
  assign ram_en_o        = xfer;
  assign ram_we_o        = we_mux;
  assign ram_addr_o      = addr_mux;
  assign ram_wdata_o     = wdata_mux;

  // Pointer and response-pending state; reset drops any in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      rsp_sel_q  <= '0;
      rsp_pend_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rsp_sel_q  <= rsp_sel_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed + randomized bench for bram_port_arbiter (2- and 3-requester
// instances), each backed by a read-first byte-write RAM model.
module tb_bram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(2)) bus2 ();
  bram_port_arbiter_if #(.NUM_REQ(3)) bus3 ();

  logic        en2, en3;
  logic [3:0]  we2, we3;
  logic [8:0]  ad2, ad3;
  logic [31:0] wd2, wd3, rd2, rd3;
  logic [31:0] mem2 [512];
  logic [31:0] mem3 [512];

  bram_port_arbiter #(.NUM_REQ(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
    .ram_en_o(en2), .ram_we_o(we2), .ram_addr_o(ad2),
    .ram_wdata_o(wd2), .ram_rdata_i(rd2)
  );

  bram_port_arbiter #(.NUM_REQ(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus3),
    .ram_en_o(en3), .ram_we_o(we3), .ram_addr_o(ad3),
    .ram_wdata_o(wd3), .ram_rdata_i(rd3)
  );

  // Read-first byte-write RAMs, one cycle read latency.
  always @(posedge clk) begin
    if (en2) begin
      rd2 <= mem2[ad2];
      for (int c = 0; c < 4; c++) if (we2[c]) mem2[ad2][c*8 +: 8] <= wd2[c*8 +: 8];
    end
    if (en3) begin
      rd3 <= mem3[ad3];
      for (int c = 0; c < 4; c++) if (we3[c]) mem3[ad3][c*8 +: 8] <= wd3[c*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random-test state (3-requester instance)
  logic        pend [3];
  logic [3:0]  rwe  [3];
  logic [8:0]  rad  [3];
  logic [31:0] rwd  [3];
  int          wcnt [3];
  logic [31:0] refm [16];
  logic [2:0]  eg, exp_rsp;
  logic [31:0] exp_dat;
  int          p, gi, j, g0cnt, g1cnt;
  logic [1:0]  exp2, prev2;

  initial begin
    for (int a = 0; a < 512; a++) begin mem2[a] = '0; mem3[a] = '0; end
    for (int a = 0; a < 16; a++) refm[a] = '0;
    bus2.req_valid_i = '0; bus2.req_we_i = '0; bus2.req_addr_i = '0; bus2.req_wdata_i = '0;
    bus3.req_valid_i = '0; bus3.req_we_i = '0; bus3.req_addr_i = '0; bus3.req_wdata_i = '0;

    // Reset: requests present but nothing granted
    rst_n = 1'b0;
    bus2.req_valid_i = 2'b11;
    #2;
    chk("rst_ready", bus2.req_ready_o, 2'b00);
    chk("rst_ram_en", en2, 1'b0);
    chk("rst_rsp", bus2.rsp_valid_o, 2'b00);
    step(); step();
    rst_n = 1'b1;
    bus2.req_valid_i = 2'b00;

    // Requester 0 writes DEADBEEF to word 5 then reads it back
    bus2.req_valid_i = 2'b01; bus2.req_we_i[3:0] = 4'hF;
    bus2.req_addr_i[8:0] = 9'd5; bus2.req_wdata_i[31:0] = 32'hDEADBEEF;
    #2;
    chk("wr_ready", bus2.req_ready_o, 2'b01);
    chk("wr_en", en2, 1'b1);
    chk("wr_we", we2, 4'hF);
    chk("wr_addr", ad2, 9'd5);
    chk("wr_data", wd2, 32'hDEADBEEF);
    chk("wr_norsp", bus2.rsp_valid_o, 2'b00);
    step();
    bus2.req_we_i[3:0] = 4'h0;
    #2;
    chk("rd_ready", bus2.req_ready_o, 2'b01);
    chk("wr_rsp", bus2.rsp_valid_o, 2'b01);
    chk("wr_rsp_old", bus2.rsp_rdata_o, 32'h0);
    step();
    bus2.req_valid_i = 2'b00;
    #2;
    chk("idle_ready", bus2.req_ready_o, 2'b00);
    chk("idle_en", en2, 1'b0);
    chk("idle_we", we2, 4'h0);
    chk("rd_rsp", bus2.rsp_valid_o, 2'b01);
    chk("rd_data", bus2.rsp_rdata_o, 32'hDEADBEEF);
    step();
    #2;
    chk("rsp_once", bus2.rsp_valid_o, 2'b00);
    step();

    // Requester 1: word 7 full write, partial column-1 write, read back
    bus2.req_valid_i = 2'b10; bus2.req_we_i[7:4] = 4'hF;
    bus2.req_addr_i[17:9] = 9'd7; bus2.req_wdata_i[63:32] = 32'h11223344;
    #2;
    chk("p_w1_ready", bus2.req_ready_o, 2'b10);
    step();
    bus2.req_we_i[7:4] = 4'b0010; bus2.req_wdata_i[63:32] = 32'hAABBCCDD;
    #2;
    chk("p_w2_ready", bus2.req_ready_o, 2'b10);
    chk("p_w1_rsp", bus2.rsp_valid_o, 2'b10);
    step();
    bus2.req_we_i[7:4] = 4'h0;
    #2;
    chk("p_rd_ready", bus2.req_ready_o, 2'b10);
    chk("p_w2_rsp", bus2.rsp_valid_o, 2'b10);
    chk("p_w2_old", bus2.rsp_rdata_o, 32'h11223344);
    step();
    bus2.req_valid_i = 2'b00;
    #2;
    chk("p_rd_rsp", bus2.rsp_valid_o, 2'b10);
    chk("p_rd_data", bus2.rsp_rdata_o, 32'h1122CC44);
    step();

    // Both requesters reading for 8 cycles: strict alternation from 0
    bus2.req_valid_i = 2'b11;
    g0cnt = 0; g1cnt = 0; prev2 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      exp2 = (i % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      chk("alt_ready", bus2.req_ready_o, exp2);
      chk("alt_rsp", bus2.rsp_valid_o, prev2);
      if (prev2 == 2'b01) chk("alt_d0", bus2.rsp_rdata_o, 32'hDEADBEEF);
      if (prev2 == 2'b10) chk("alt_d1", bus2.rsp_rdata_o, 32'h1122CC44);
      if (bus2.req_ready_o[0]) g0cnt++;
      if (bus2.req_ready_o[1]) g1cnt++;
      prev2 = exp2;
      step();
    end
    bus2.req_valid_i = 2'b00;
    #2;
    chk("alt_last_rsp", bus2.rsp_valid_o, 2'b10);
    chk("alt_cnt0", g0cnt, 4);
    chk("alt_cnt1", g1cnt, 4);
    step();

    // Reset pulsed in the response cycle of a read: response is dropped
    bus2.req_valid_i = 2'b01;
    #2;
    chk("rr_ready", bus2.req_ready_o, 2'b01);
    step();
    rst_n = 1'b0;
    bus2.req_valid_i = 2'b11;
    #1;
    chk("rr_rsp_drop", bus2.rsp_valid_o, 2'b00);
    chk("rr_rst_ready", bus2.req_ready_o, 2'b00);
    chk("rr_rst_en", en2, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rr_post_ready", bus2.req_ready_o, 2'b01);
    chk("rr_post_rsp", bus2.rsp_valid_o, 2'b00);
    step();
    bus2.req_valid_i = 2'b00;
    #2;
    chk("rr_new_rsp", bus2.rsp_valid_o, 2'b01);
    chk("rr_new_data", bus2.rsp_rdata_o, 32'hDEADBEEF);
    step();

    // 3 requesters: only requester 2 for 4 cycles, pointer wraps to 0
    bus3.req_valid_i = 3'b100;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("r2_ready", bus3.req_ready_o, 3'b100);
      chk("r2_rsp", bus3.rsp_valid_o, (i == 0) ? 3'b000 : 3'b100);
      step();
    end
    bus3.req_valid_i = 3'b111;
    #2;
    chk("wrap_ready", bus3.req_ready_o, 3'b001);
    chk("wrap_rsp", bus3.rsp_valid_o, 3'b100);
    step();
    bus3.req_valid_i = 3'b000;
    #2;
    chk("wrap_rsp0", bus3.rsp_valid_o, 3'b001);
    step();

    // Random traffic against a reference memory and round-robin model
    p = 1; exp_rsp = '0; exp_dat = '0;
    for (int r = 0; r < 3; r++) begin pend[r] = 1'b0; wcnt[r] = 0; rwe[r] = '0; rad[r] = '0; rwd[r] = '0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int r = 0; r < 3; r++) begin
        if (!pend[r] && ($urandom % 2 == 0)) begin
          pend[r] = 1'b1;
          rwe[r]  = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16);
          rad[r]  = 9'($urandom % 16);
          rwd[r]  = $urandom;
        end
        bus3.req_valid_i[r]          = pend[r];
        bus3.req_we_i[r*4 +: 4]      = rwe[r];
        bus3.req_addr_i[r*9 +: 9]    = rad[r];
        bus3.req_wdata_i[r*32 +: 32] = rwd[r];
      end
      eg = '0; gi = -1;
      for (int k = 0; k < 3; k++) begin
        j = (p + k) % 3;
        if (gi < 0 && pend[j]) begin eg[j] = 1'b1; gi = j; end
      end
      #2;
      chk("rnd_ready", bus3.req_ready_o, eg);
      chk("rnd_rsp", bus3.rsp_valid_o, exp_rsp);
      if (exp_rsp != 3'b000) chk("rnd_data", bus3.rsp_rdata_o, exp_dat);
      if (gi >= 0) begin
        chk("rnd_fair", wcnt[gi] <= 2, 1'b1);
        wcnt[gi] = 0;
        for (int r = 0; r < 3; r++) if (r != gi && pend[r]) wcnt[r]++;
        exp_dat = refm[rad[gi][3:0]];
        for (int c = 0; c < 4; c++)
          if (rwe[gi][c]) refm[rad[gi][3:0]][c*8 +: 8] = rwd[gi][c*8 +: 8];
        pend[gi] = 1'b0;
        p = (gi + 1) % 3;
      end
      exp_rsp = eg;
      step();
    end
    bus3.req_valid_i = '0;
    #2;
    chk("rnd_tail_rsp", bus3.rsp_valid_o, exp_rsp);
    if (exp_rsp != 3'b000) chk("rnd_tail_data", bus3.rsp_rdata_o, exp_dat);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
